bch_correct: RTL

Error-correction output stage of the serial BCH decoder, directly downstream of the Chien search. It holds each received codeword's K data bits in a two-bank buffer while syndrome computation and the error-locator solve run. It then XORs the Chien search's per-position error flag onto the buffered bits and emits the corrected data stream. It also counts corrections and flags a decode failure when that count disagrees with the error-locator degree.

---
 rtl/bch_pkg.sv | 25 ++
 rtl/bch_bank.sv | 71 +++++++
 rtl/bch_correct.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bch_pkg.sv
// Shared definitions for the BCH correction output stage: bank-state
// encoding and width helpers used by bch_bank and bch_correct.
package bch_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // Ceiling log2, never narrower than one bit so it can size a vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Width of the error-locator degree and the correction count for T errors.
  function automatic int BCH_DEG_W(input int t);
    return clog2(t + 1);
  endfunction

endpackage

// File: rtl/bch_bank.sv
// One K-bit codeword buffer bank with its own write index, read index and
// EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY life cycle. The parent only
// asserts wr_en while the bank is EMPTY/FILLING and rd_start/rd_en while it
// is FULL/DRAINING, so the write and read sides never touch the bank at once.
module bch_bank
  import bch_pkg::*;
#(
  parameter int K = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        wr_start,
  input  logic        wr_data,
  input  logic        rd_start,
  input  logic        rd_en,
  output bank_state_t state,
  output logic        wr_done,
  output logic        rd_done,
  output logic        rd_data
);

  localparam int IW = clog2(K);
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  logic [K-1:0]  mem;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] rd_sel;

  // A start pulse reads position 0; otherwise the running read index is used.
  always_comb begin
    rd_sel  = rd_start ? '0 : rd_idx;
    rd_data = mem[rd_sel];
    rd_done = (rd_start | rd_en) & (rd_sel == LAST);
    wr_done = wr_en & (wr_start ? (K == 1)
                                : ((state == BANK_FILLING) && (wr_idx == LAST)));
  end

  // Store incoming bits, advance the read position and walk the bank state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BANK_EMPTY;
      wr_idx <= '0;
      rd_idx <= '0;
      mem    <= '0;
    end else begin
      if (wr_en) begin
        if (wr_start) begin
          mem[0] <= wr_data;
          wr_idx <= IW'(1);
          state  <= (K == 1) ? BANK_FULL : BANK_FILLING;
        end else if (state == BANK_FILLING) begin
          mem[wr_idx] <= wr_data;
          wr_idx      <= wr_idx + 1'b1;
          if (wr_idx == LAST) state <= BANK_FULL;
        end
      end
      if (rd_start | rd_en) begin
        if (rd_done) begin
          rd_idx <= '0;
          state  <= BANK_EMPTY;
        end else begin
          rd_idx <= rd_sel + 1'b1;
          if (rd_start) state <= BANK_DRAINING;
        end
      end
    end
  end

endmodule

// File: rtl/bch_correct.sv
// Error-correction output stage of the serial BCH decoder. Buffers each
// codeword's K data bits in two ping-pong banks, XORs the Chien error flag
// onto the stored bits and emits the corrected stream one cycle later.
// Optional feature macro: BCH_CORRECT_COUNT_EN enables the correction
// counter, the degree latch and the decode-failure flag; without it
// err_count and fail are held at 0.
module bch_correct
  import bch_pkg::*;
#(
  parameter int M = 4,
  parameter int T = 3,
  parameter int K = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_start,
  input  logic                    in_valid,
  input  logic                    in_data,
  output logic                    in_ready,
  input  logic                    ch_start,
  input  logic                    ch_valid,
  input  logic                    ch_err,
  input  logic [BCH_DEG_W(T)-1:0] deg,
  output logic                    out_valid,
  output logic                    out_first,
  output logic                    out_last,
  output logic                    out_data,
  output logic [BCH_DEG_W(T)-1:0] err_count,
  output logic                    fail,
  output logic                    underrun
);

  localparam int DW = BCH_DEG_W(T);
  localparam logic [DW-1:0] T_MAX = DW'(T);
  localparam int unused_m = M;

  logic        wp;
  logic        rp;
  bank_state_t bank_state [2];
  logic [1:0]  bank_wr_done;
  logic [1:0]  bank_rd_done;
  logic [1:0]  bank_rd_data;
  logic        wr_fire;
  logic        ch_accept;
  logic        ch_drain;
  logic        ch_underrun;
  logic        emit;
  logic        wr_done;
  logic        rd_done;
  logic        rd_bit;

  // Steer the write side to bank wp and the Chien side to bank rp.
  always_comb begin
    in_ready    = (bank_state[wp] == BANK_EMPTY) || (bank_state[wp] == BANK_FILLING);
    wr_fire     = in_valid & in_ready;
    ch_accept   = ch_valid & ch_start & (bank_state[rp] == BANK_FULL);
    ch_underrun = ch_valid & ch_start & (bank_state[rp] != BANK_FULL);
    ch_drain    = ch_valid & ~ch_start & (bank_state[rp] == BANK_DRAINING);
    emit        = ch_accept | ch_drain;
    wr_done     = bank_wr_done[wp];
    rd_done     = bank_rd_done[rp];
    rd_bit      = bank_rd_data[rp];
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    bch_bank #(.K(K)) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_fire & (wp == 1'(g))),
      .wr_start (in_start),
      .wr_data  (in_data),
      .rd_start (ch_accept & (rp == 1'(g))),
      .rd_en    (ch_drain & (rp == 1'(g))),
      .state    (bank_state[g]),
      .wr_done  (bank_wr_done[g]),
      .rd_done  (bank_rd_done[g]),
      .rd_data  (bank_rd_data[g])
    );
  end

  // Move to the other bank once a word is completely written or read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 1'b0;
      rp <= 1'b0;
    end else begin
      if (wr_done) wp <= ~wp;
      if (rd_done) rp <= ~rp;
    end
  end

  // Register the corrected bit and its framing one cycle after ch_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 1'b0;
    end else begin
      out_valid <= emit;
      out_first <= ch_accept;
      out_last  <= rd_done;
      out_data  <= emit & (rd_bit ^ ch_err);
    end
  end

  // Remember any Chien start that found no complete word waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else if (ch_underrun) begin
      underrun <= 1'b1;
    end
  end

`ifdef BCH_CORRECT_COUNT_EN
  logic [DW-1:0] cnt;
  logic [DW-1:0] deg_q;
  logic [DW-1:0] cnt_base;
  logic [DW-1:0] cnt_next;
  logic [DW-1:0] deg_sel;

  // Count including the current position; a new word starts from zero.
  always_comb begin
    cnt_base = ch_accept ? '0 : cnt;
    cnt_next = (ch_err && (cnt_base < T_MAX)) ? cnt_base + 1'b1 : cnt_base;
    deg_sel  = ch_accept ? deg : deg_q;
  end

  // Track corrections per word and publish count and failure on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      deg_q     <= '0;
      err_count <= '0;
      fail      <= 1'b0;
    end else if (emit) begin
      cnt <= cnt_next;
      if (ch_accept) deg_q <= deg;
      if (rd_done) begin
        err_count <= cnt_next;
        fail      <= (cnt_next != deg_sel) || (deg_sel > T_MAX);
      end
    end
  end
`else
  logic unused_deg;

  assign unused_deg = ^deg;
  assign err_count  = '0;
  assign fail       = 1'b0;
`endif

endmodule
